// File: rtl/tx_dma_usr_pkt_checker.sv
// Single-region MFB pass-through with one register stage. A framing checker watches the
// accepted words, flags size/framing errors and keeps saturating per-channel statistics.
module tx_dma_usr_pkt_checker #(
  parameter int unsigned REGION_SIZE  = 8,
  parameter int unsigned BLOCK_SIZE   = 8,
  parameter int unsigned ITEM_WIDTH   = 8,
  parameter int unsigned CHANNELS     = 8,
  parameter int unsigned PKT_SIZE_MAX = 2**12,
  parameter int unsigned CNTRS_WIDTH  = 32,
  localparam int unsigned W   = REGION_SIZE*BLOCK_SIZE,
  localparam int unsigned DW  = W*ITEM_WIDTH,
  localparam int unsigned SW  = $clog2(PKT_SIZE_MAX+1),
  localparam int unsigned CHW = $clog2(CHANNELS),
  localparam int unsigned SPW = (REGION_SIZE > 1) ? $clog2(REGION_SIZE) : 1,
  localparam int unsigned EPW = $clog2(W)
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [DW-1:0]          RX_DATA,
  input  logic [SW-1:0]          RX_META_PKT_SIZE,
  input  logic [CHW-1:0]         RX_META_CHAN,
  input  logic [23:0]            RX_META_HDR_META,
  input  logic                   RX_SOF,
  input  logic                   RX_EOF,
  input  logic [SPW-1:0]         RX_SOF_POS,
  input  logic [EPW-1:0]         RX_EOF_POS,
  input  logic                   RX_SRC_RDY,
  output logic                   RX_DST_RDY,
  output logic [DW-1:0]          TX_DATA,
  output logic [SW-1:0]          TX_META_PKT_SIZE,
  output logic [CHW-1:0]         TX_META_CHAN,
  output logic [23:0]            TX_META_HDR_META,
  output logic                   TX_SOF,
  output logic                   TX_EOF,
  output logic [SPW-1:0]         TX_SOF_POS,
  output logic [EPW-1:0]         TX_EOF_POS,
  output logic                   TX_SRC_RDY,
  input  logic                   TX_DST_RDY,
  output logic                   ERR_VLD,
  output logic [1:0]             ERR_CODE,
  output logic [CHW-1:0]         ERR_CHAN,
  input  logic [CHW-1:0]         CNT_RD_CHAN,
  output logic [CNTRS_WIDTH-1:0] CNT_PKTS,
  output logic [CNTRS_WIDTH-1:0] CNT_ERRS,
  input  logic                   CNT_CLR
);

  localparam int unsigned CW = SW + 1;

  typedef enum logic {IDLE, IN_PKT} state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          bcnt_q, bcnt_d;
  logic [SW-1:0]          size_q;
  logic [CHW-1:0]         chan_q;
  logic [23:0]            hdr_q;

  logic [DW-1:0]          tx_data_q;
  logic                   tx_sof_q, tx_eof_q, tx_src_rdy_q;
  logic [SPW-1:0]         tx_sof_pos_q;
  logic [EPW-1:0]         tx_eof_pos_q;

  logic                   err_vld_q, err_d;
  logic [1:0]             err_code_q, err_code_d;
  logic [CHW-1:0]         err_chan_q, err_chan_d;
  logic                   pkt_end;
  logic [CHW-1:0]         pkt_chan;

  logic                   accept, eof_first;
  logic [CW-1:0]          sof_off, eof_len, end_bytes, single_len;

  logic [CNTRS_WIDTH-1:0] pkts_q [CHANNELS];
  logic [CNTRS_WIDTH-1:0] errs_q [CHANNELS];
  logic [CNTRS_WIDTH-1:0] rd_pkts_q, rd_errs_q;

  function automatic logic [CW-1:0] sat_add(input logic [CW-1:0] a, input logic [CW-1:0] b);
    logic [CW:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CW] ? '1 : s[CW-1:0];
  endfunction

  assign RX_DST_RDY = TX_DST_RDY | ~tx_src_rdy_q;
  assign accept     = RX_SRC_RDY & RX_DST_RDY;

  assign sof_off    = CW'(RX_SOF_POS) * CW'(BLOCK_SIZE);
  assign eof_len    = CW'(RX_EOF_POS) + CW'(1);
  assign eof_first  = CW'(RX_EOF_POS) < sof_off;
  assign end_bytes  = sat_add(bcnt_q, eof_len);
  assign single_len = CW'(RX_EOF_POS) - sof_off + CW'(1);

  always_comb begin
    state_d    = state_q;
    bcnt_d     = bcnt_q;
    err_d      = 1'b0;
    err_code_d = '0;
    err_chan_d = chan_q;
    pkt_end    = 1'b0;
    pkt_chan   = chan_q;
    if (accept) begin
      if (RX_SOF && RX_EOF && !eof_first) begin
        // Complete single-word packet; an open packet is abandoned and takes priority.
        pkt_end  = 1'b1;
        pkt_chan = RX_META_CHAN;
        if (state_q == IN_PKT) begin
          err_d      = 1'b1;
          err_code_d = 2'd2;
        end else if (single_len != CW'(RX_META_PKT_SIZE)) begin
          err_d      = 1'b1;
          err_code_d = 2'd1;
          err_chan_d = RX_META_CHAN;
        end
        state_d = IDLE;
        bcnt_d  = '0;
      end else if (RX_SOF) begin
        if (state_q == IN_PKT && RX_EOF) begin
          pkt_end = 1'b1;
          if (end_bytes != CW'(size_q)) begin
            err_d      = 1'b1;
            err_code_d = 2'd1;
          end
        end else if (state_q == IN_PKT) begin
          err_d      = 1'b1;
          err_code_d = 2'd2;
        end else if (RX_EOF) begin
          err_d      = 1'b1;
          err_code_d = 2'd3;
        end
        state_d = IN_PKT;
        bcnt_d  = CW'(W) - sof_off;
      end else if (state_q == IDLE) begin
        err_d      = 1'b1;
        err_code_d = 2'd3;
      end else if (RX_EOF) begin
        pkt_end = 1'b1;
        if (end_bytes != CW'(size_q)) begin
          err_d      = 1'b1;
          err_code_d = 2'd1;
        end
        state_d = IDLE;
        bcnt_d  = '0;
      end else begin
        bcnt_d = sat_add(bcnt_q, CW'(W));
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      tx_src_rdy_q <= 1'b0;
      state_q      <= IDLE;
      bcnt_q       <= '0;
      size_q       <= '0;
      chan_q       <= '0;
      hdr_q        <= '0;
      err_vld_q    <= 1'b0;
      err_code_q   <= '0;
      err_chan_q   <= '0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      if (accept) begin
        tx_src_rdy_q <= 1'b1;
      end else if (TX_DST_RDY) begin
        tx_src_rdy_q <= 1'b0;
      end
      if (accept && RX_SOF) begin
        size_q <= RX_META_PKT_SIZE;
        chan_q <= RX_META_CHAN;
        hdr_q  <= RX_META_HDR_META;
      end
      err_vld_q  <= err_d;
      err_code_q <= err_code_d;
      err_chan_q <= err_d ? err_chan_d : '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (accept) begin
      tx_data_q    <= RX_DATA;
      tx_sof_q     <= RX_SOF;
      tx_eof_q     <= RX_EOF;
      tx_sof_pos_q <= RX_SOF_POS;
      tx_eof_pos_q <= RX_EOF_POS;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET || CNT_CLR) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        pkts_q[i] <= '0;
        errs_q[i] <= '0;
      end
    end else begin
      if (pkt_end && pkts_q[pkt_chan] != '1) begin
        pkts_q[pkt_chan] <= pkts_q[pkt_chan] + CNTRS_WIDTH'(1);
      end
      if (err_d && errs_q[err_chan_d] != '1) begin
        errs_q[err_chan_d] <= errs_q[err_chan_d] + CNTRS_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      rd_pkts_q <= '0;
      rd_errs_q <= '0;
    end else begin
      rd_pkts_q <= pkts_q[CNT_RD_CHAN];
      rd_errs_q <= errs_q[CNT_RD_CHAN];
    end
  end

  // Packet meta is held per packet, so it doubles as the TX meta of every word in it.
  assign TX_DATA          = tx_data_q;
  assign TX_META_PKT_SIZE = size_q;
  assign TX_META_CHAN     = chan_q;
  assign TX_META_HDR_META = hdr_q;
  assign TX_SOF           = tx_sof_q;
  assign TX_EOF           = tx_eof_q;
  assign TX_SOF_POS       = tx_sof_pos_q;
  assign TX_EOF_POS       = tx_eof_pos_q;
  assign TX_SRC_RDY       = tx_src_rdy_q;
  assign ERR_VLD          = err_vld_q;
  assign ERR_CODE         = err_code_q;
  assign ERR_CHAN         = err_chan_q;
  assign CNT_PKTS         = rd_pkts_q;
  assign CNT_ERRS         = rd_errs_q;

endmodule

// File: tb/tb_tx_dma_usr_pkt_checker.sv
// Scoreboard bench: a packet-level reference model predicts every TX word and error,
// a separate monitor compares whatever the DUT presents on TX.
`timescale 1ns/1ps
module tb_tx_dma_usr_pkt_checker;
  localparam int unsigned RS = 8, BS = 8, IW = 8, CH = 8, PMAX = 4096, CNTW = 4;
  localparam int unsigned W = RS*BS, DW = W*IW, SW = $clog2(PMAX+1);
  localparam int unsigned CHW = $clog2(CH), SPW = $clog2(RS), EPW = $clog2(W);
  localparam int CMAX = (1 << CNTW) - 1;
  localparam int BSAT = (1 << (SW+1)) - 1;

  logic            CLK = 1'b0, RESET = 1'b0;
  logic [DW-1:0]   RX_DATA = '0, TX_DATA;
  logic [SW-1:0]   RX_META_PKT_SIZE = '0, TX_META_PKT_SIZE;
  logic [CHW-1:0]  RX_META_CHAN = '0, TX_META_CHAN;
  logic [23:0]     RX_META_HDR_META = '0, TX_META_HDR_META;
  logic            RX_SOF = 1'b0, RX_EOF = 1'b0, TX_SOF, TX_EOF;
  logic [SPW-1:0]  RX_SOF_POS = '0, TX_SOF_POS;
  logic [EPW-1:0]  RX_EOF_POS = '0, TX_EOF_POS;
  logic            RX_SRC_RDY = 1'b0, RX_DST_RDY, TX_SRC_RDY, TX_DST_RDY = 1'b1;
  logic            ERR_VLD;
  logic [1:0]      ERR_CODE;
  logic [CHW-1:0]  ERR_CHAN, CNT_RD_CHAN = '0;
  logic [CNTW-1:0] CNT_PKTS, CNT_ERRS;
  logic            CNT_CLR = 1'b0;

  tx_dma_usr_pkt_checker #(
    .REGION_SIZE(RS), .BLOCK_SIZE(BS), .ITEM_WIDTH(IW), .CHANNELS(CH),
    .PKT_SIZE_MAX(PMAX), .CNTRS_WIDTH(CNTW)
  ) dut (
    .CLK(CLK), .RESET(RESET),
    .RX_DATA(RX_DATA), .RX_META_PKT_SIZE(RX_META_PKT_SIZE), .RX_META_CHAN(RX_META_CHAN),
    .RX_META_HDR_META(RX_META_HDR_META), .RX_SOF(RX_SOF), .RX_EOF(RX_EOF),
    .RX_SOF_POS(RX_SOF_POS), .RX_EOF_POS(RX_EOF_POS), .RX_SRC_RDY(RX_SRC_RDY), .RX_DST_RDY(RX_DST_RDY),
    .TX_DATA(TX_DATA), .TX_META_PKT_SIZE(TX_META_PKT_SIZE), .TX_META_CHAN(TX_META_CHAN),
    .TX_META_HDR_META(TX_META_HDR_META), .TX_SOF(TX_SOF), .TX_EOF(TX_EOF),
    .TX_SOF_POS(TX_SOF_POS), .TX_EOF_POS(TX_EOF_POS), .TX_SRC_RDY(TX_SRC_RDY), .TX_DST_RDY(TX_DST_RDY),
    .ERR_VLD(ERR_VLD), .ERR_CODE(ERR_CODE), .ERR_CHAN(ERR_CHAN),
    .CNT_RD_CHAN(CNT_RD_CHAN), .CNT_PKTS(CNT_PKTS), .CNT_ERRS(CNT_ERRS), .CNT_CLR(CNT_CLR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [DW-1:0]            data;
    logic [SPW+EPW+1:0]       ctl;
    logic [SW+CHW+23:0]       meta;
    int                       code;
    int                       echan;
  } exp_t;

  exp_t sb[$];
  int   checks = 0, errors = 0;
  bit   rand_bp = 1'b0;
  bit   mon_fresh = 1'b1;

  bit m_in;
  int m_cnt, m_size, m_chan, m_hdr;
  int m_pkts[CH], m_errs[CH];

  function automatic void chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endfunction

  function automatic void model_reset();
    m_in = 1'b0; m_cnt = 0; m_size = 0; m_chan = 0; m_hdr = 0;
    for (int c = 0; c < CH; c++) begin m_pkts[c] = 0; m_errs[c] = 0; end
  endfunction

  // Close the open packet: count it on its channel and report whether its size disagrees.
  function automatic int close_pkt(int bytes);
    m_in = 1'b0;
    if (m_pkts[m_chan] < CMAX) m_pkts[m_chan]++;
    if (bytes > BSAT) bytes = BSAT;
    return (bytes != m_size) ? 1 : 0;
  endfunction

  function automatic void model_word(bit sof, bit eof, int sp, int ep, int size, int chan,
                                     int hdr, bit clr, logic [DW-1:0] data);
    exp_t e;
    int ecode = 0, echan = 0;
    int soff = sp*BS;
    bit ends_first = sof && eof && (ep < soff);
    if (!sof) begin
      if (!m_in) begin ecode = 3; echan = m_chan; end
      else if (eof) begin ecode = close_pkt(m_cnt + ep + 1); echan = m_chan; end
      else m_cnt = (m_cnt + W > BSAT) ? BSAT : m_cnt + W;
    end else begin
      if (ends_first) begin
        if (m_in) begin ecode = close_pkt(m_cnt + ep + 1); echan = m_chan; end
        else begin ecode = 3; echan = m_chan; end
      end else if (m_in) begin
        ecode = 2; echan = m_chan;
      end
      m_size = size; m_chan = chan; m_hdr = hdr;
      if (eof && !ends_first) begin
        if (m_pkts[chan] < CMAX) m_pkts[chan]++;
        if (ecode == 0 && (ep - soff + 1) != size) begin ecode = 1; echan = chan; end
        m_in = 1'b0;
      end else begin
        m_in = 1'b1; m_cnt = W - soff;
      end
    end
    if (ecode != 0 && m_errs[echan] < CMAX) m_errs[echan]++;
    if (clr) for (int c = 0; c < CH; c++) begin m_pkts[c] = 0; m_errs[c] = 0; end
    e.data  = data;
    e.ctl   = {sof, eof, SPW'(sp), EPW'(ep)};
    e.meta  = {SW'(m_size), CHW'(m_chan), 24'(m_hdr)};
    e.code  = ecode;
    e.echan = (ecode != 0) ? echan : 0;
    sb.push_back(e);
  endfunction

  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (RESET) begin
        mon_fresh = 1'b1;
      end else begin
        if (TX_SRC_RDY && mon_fresh) begin
          if (sb.size() == 0) begin
            chk("tx_unexpected_word", 1, 0);
          end else begin
            chk("err_vld", ERR_VLD, sb[0].code != 0);
            chk("err_code", ERR_CODE, sb[0].code);
            chk("err_chan", ERR_CHAN, sb[0].echan);
          end
        end else begin
          chk("err_vld_idle", ERR_VLD, 0);
        end
        if (TX_SRC_RDY && TX_DST_RDY && sb.size() != 0) begin
          e = sb.pop_front();
          chk("tx_data", TX_DATA, e.data);
          chk("tx_ctl", {TX_SOF, TX_EOF, TX_SOF_POS, TX_EOF_POS}, e.ctl);
          chk("tx_meta", {TX_META_PKT_SIZE, TX_META_CHAN, TX_META_HDR_META}, e.meta);
        end
        mon_fresh = !TX_SRC_RDY || TX_DST_RDY;
      end
    end
  end

  initial begin
    forever begin
      @(posedge CLK); #1;
      TX_DST_RDY = rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic send(input bit sof, input bit eof, input int sp, input int ep,
                      input int size, input int chan, input bit clr = 1'b0);
    logic [DW-1:0] d;
    int hdr;
    int n = 0;
    for (int i = 0; i < DW/32; i++) d[i*32 +: 32] = $urandom;
    hdr = $urandom_range(0, 32'hFFFFFF);
    RX_DATA = d; RX_SOF = sof; RX_EOF = eof;
    RX_SOF_POS = SPW'(sp); RX_EOF_POS = EPW'(ep);
    RX_META_PKT_SIZE = SW'(size); RX_META_CHAN = CHW'(chan); RX_META_HDR_META = 24'(hdr);
    CNT_CLR = clr; RX_SRC_RDY = 1'b1;
    forever begin
      @(negedge CLK);
      if (RX_DST_RDY) break;
      n++;
      if (n > 100) begin
        $display("FAIL rx_accept_timeout actual=%0d expected=<=100", n);
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "rx stalled");
      end
    end
    model_word(sof, eof, sp, ep, size, chan, hdr, clr, d);
    @(posedge CLK); #1;
    RX_SRC_RDY = 1'b0; CNT_CLR = 1'b0; RX_SOF = 1'b0; RX_EOF = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin @(posedge CLK); #1; n++; end
    chk("drain_pending", sb.size(), 0);
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    sb.delete();
    model_reset();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_tx_src_rdy", TX_SRC_RDY, 0);
    chk("rst_err_vld", ERR_VLD, 0);
    chk("rst_err_code", ERR_CODE, 0);
    chk("rst_err_chan", ERR_CHAN, 0);
    chk("rst_cnt_pkts", CNT_PKTS, 0);
    chk("rst_cnt_errs", CNT_ERRS, 0);
    chk("rst_tx_meta", {TX_META_PKT_SIZE, TX_META_CHAN, TX_META_HDR_META}, 0);
    @(posedge CLK); #1;
    RESET = 1'b0;
  endtask

  task automatic check_chan(input int c);
    CNT_RD_CHAN = CHW'(c);
    @(posedge CLK);
    @(negedge CLK);
    chk($sformatf("cnt_pkts_ch%0d", c), CNT_PKTS, m_pkts[c]);
    chk($sformatf("cnt_errs_ch%0d", c), CNT_ERRS, m_errs[c]);
    @(posedge CLK); #1;
  endtask

  task automatic check_all();
    for (int c = 0; c < CH; c++) check_chan(c);
  endtask

  task automatic pulse_clr();
    CNT_CLR = 1'b1;
    @(posedge CLK); #1;
    CNT_CLR = 1'b0;
    for (int c = 0; c < CH; c++) begin m_pkts[c] = 0; m_errs[c] = 0; end
  endtask

  initial begin
    bit s, e;
    int sp, ep, ch, sz;
    do_reset();

    // Lone EOF straight after reset.
    send(0, 1, 0, 5, 6, 1);
    // Single-word packet, 52 bytes, channel 3.
    send(1, 1, 1, 59, 52, 3);
    // Three-word packets of 138 bytes: correct size, then declared 140.
    send(1, 0, 0, 0, 138, 5); send(0, 0, 0, 0, 0, 0); send(0, 1, 0, 9, 0, 0);
    send(1, 0, 0, 0, 140, 5); send(0, 0, 0, 0, 0, 0); send(0, 1, 0, 9, 0, 0);
    // EOF at 15 closes a 24-byte packet, SOF at block 4 opens a 64-byte one.
    send(1, 0, 7, 0, 24, 1);
    send(1, 1, 4, 15, 64, 6);
    send(0, 1, 0, 31, 0, 0);
    // SOF, SOF without EOF in between.
    send(1, 0, 0, 0, 100, 2);
    send(1, 0, 0, 0, 100, 4);
    send(0, 1, 0, 35, 0, 0);
    drain();
    check_all();

    rand_bp = 1'b1;
    for (int i = 0; i < 400; i++) begin
      s  = ($urandom_range(0, 3) == 0);
      e  = ($urandom_range(0, 3) == 0);
      sp = $urandom_range(0, RS-1);
      ep = $urandom_range(0, W-1);
      ch = $urandom_range(0, CH-1);
      sz = $urandom_range(1, 300);
      if (s && e && ep >= sp*BS && $urandom_range(0, 1) == 1) sz = ep - sp*BS + 1;
      send(s, e, sp, ep, sz, ch);
      if ($urandom_range(0, 7) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge CLK);
        #1;
      end
    end
    rand_bp = 1'b0;
    drain();
    check_all();

    // Saturation, then a clear coinciding with a packet end.
    pulse_clr();
    for (int i = 0; i < CMAX + 1; i++) send(1, 1, 0, 63, 64, 2);
    drain();
    check_chan(2);
    send(1, 1, 0, 63, 64, 2, 1'b1);
    drain();
    check_chan(2);

    // Reset inside a packet; the following EOF must be treated as orphaned.
    send(1, 0, 0, 0, 128, 5);
    drain();
    do_reset();
    send(0, 1, 0, 63, 0, 0);
    send(1, 1, 2, 40, 25, 7);
    drain();
    check_chan(0);
    check_chan(5);
    check_chan(7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
